// File: rtl/decode_pkg.sv
// Shared decode types: uop class encoding, uop payload and RV32 opcode/funct constants.
package decode_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CLS_W = 3;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [CLS_W-1:0] {
    CLS_NOP     = 3'd0,
    CLS_ALU     = 3'd1,
    CLS_MUL     = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_ILLEGAL = 3'd7
  } uop_cls_e;

  typedef struct packed {
    uop_cls_e         cls;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [XLEN-1:0]  imm;
    logic             sub;
  } uop_t;

  localparam logic [6:0]      OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]      OPC_STORE  = 7'b0100011;
  localparam logic [6:0]      OPC_OP     = 7'b0110011;
  localparam logic [6:0]      OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0]      F3_ADD     = 3'b000;
  localparam logic [6:0]      F7_ADD     = 7'b0000000;
  localparam logic [6:0]      F7_SUB     = 7'b0100000;
  localparam logic [6:0]      F7_MUL     = 7'b0000001;
  localparam logic [XLEN-1:0] NOP_WORD   = 32'h0000_0013;

endpackage

// File: rtl/rv_decode.sv
// Combinational single-word decoder: one 32-bit instruction to one uop.
module rv_decode
  import decode_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output uop_t            uop_c
);

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign i_imm  = {{20{instr[31]}}, instr[31:20]};
  assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};

  // Unrecognised encodings fall through as ILLEGAL with zero operand fields.
  always_comb begin
    uop_c     = '0;
    uop_c.cls = CLS_ILLEGAL;
    if (instr == NOP_WORD) begin
      uop_c.cls = CLS_NOP;
    end else begin
      case (opcode)
        OPC_LOAD: begin
          uop_c.cls = CLS_LOAD;
          uop_c.rd  = instr[11:7];
          uop_c.rs1 = instr[19:15];
          uop_c.imm = i_imm;
        end
        OPC_STORE: begin
          uop_c.cls = CLS_STORE;
          uop_c.rs1 = instr[19:15];
          uop_c.rs2 = instr[24:20];
          uop_c.imm = s_imm;
        end
        OPC_OP: begin
          if (funct3 == F3_ADD &&
              (funct7 == F7_ADD || funct7 == F7_SUB || funct7 == F7_MUL)) begin
            uop_c.cls = (funct7 == F7_MUL) ? CLS_MUL : CLS_ALU;
            uop_c.sub = (funct7 == F7_SUB);
            uop_c.rd  = instr[11:7];
            uop_c.rs1 = instr[19:15];
            uop_c.rs2 = instr[24:20];
          end
        end
        OPC_OP_IMM: begin
          if (funct3 == F3_ADD) begin
            uop_c.cls = CLS_ALU;
            uop_c.rd  = instr[11:7];
            uop_c.rs1 = instr[19:15];
            uop_c.imm = i_imm;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/dual_issue_decoder.sv
// Two-wide front-end decoder feeding a 2-entry in-order uop buffer drained by dispatch.
module dual_issue_decoder
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   instr1,
  input  logic [XLEN-1:0]   instr2,
  output logic [1:0]        shift_count,
  input  logic [1:0]        accept_count,
  output logic              uop0_valid,
  output logic [CLS_W-1:0]  uop0_cls,
  output logic [REG_W-1:0]  uop0_rd,
  output logic [REG_W-1:0]  uop0_rs1,
  output logic [REG_W-1:0]  uop0_rs2,
  output logic [XLEN-1:0]   uop0_imm,
  output logic              uop0_sub,
  output logic              uop1_valid,
  output logic [CLS_W-1:0]  uop1_cls,
  output logic [REG_W-1:0]  uop1_rd,
  output logic [REG_W-1:0]  uop1_rs1,
  output logic [REG_W-1:0]  uop1_rs2,
  output logic [XLEN-1:0]   uop1_imm,
  output logic              uop1_sub,
  output logic              halted,
  output logic [CNT_W-1:0]  issued_cnt
);

  uop_t       slot0_q, slot1_q;
  logic [1:0] occ_q;
  uop_t       dec1_c, dec2_c;
  logic [1:0] room_c, acc_c, eff_c, nxt_occ_c;
  logic       ill_c;
  uop_t       nxt0_c, nxt1_c;

  rv_decode u_dec1 (.instr(instr1), .uop_c(dec1_c));
  rv_decode u_dec2 (.instr(instr2), .uop_c(dec2_c));

  // Room comes from registered occupancy only; an illegal word truncates the shift at itself.
  always_comb begin
    room_c      = halted ? 2'd0 : 2'd2 - occ_q;
    shift_count = room_c;
    ill_c       = 1'b0;
    if (room_c != 2'd0 && dec1_c.cls == CLS_ILLEGAL) begin
      shift_count = 2'd0;
      ill_c       = 1'b1;
    end else if (room_c == 2'd2 && dec2_c.cls == CLS_ILLEGAL) begin
      shift_count = 2'd1;
      ill_c       = 1'b1;
    end
  end

  assign acc_c = (accept_count == 2'b11) ? 2'd2 : accept_count;
  assign eff_c = (acc_c < occ_q) ? acc_c : occ_q;

  // Survivors compact toward slot 0, then shifted non-NOP words append in program order.
  always_comb begin
    nxt0_c    = '0;
    nxt1_c    = '0;
    nxt_occ_c = occ_q - eff_c;
    if (eff_c == 2'd0) begin
      nxt0_c = slot0_q;
      nxt1_c = slot1_q;
    end else if (eff_c == 2'd1) begin
      nxt0_c = slot1_q;
    end
    if (shift_count != 2'd0 && dec1_c.cls != CLS_NOP) begin
      if (nxt_occ_c == 2'd0) nxt0_c = dec1_c;
      else                   nxt1_c = dec1_c;
      nxt_occ_c = nxt_occ_c + 2'd1;
    end
    if (shift_count == 2'd2 && dec2_c.cls != CLS_NOP) begin
      if (nxt_occ_c == 2'd0) nxt0_c = dec2_c;
      else                   nxt1_c = dec2_c;
      nxt_occ_c = nxt_occ_c + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q      <= 2'd0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      halted     <= 1'b0;
      issued_cnt <= '0;
    end else begin
      occ_q      <= nxt_occ_c;
      slot0_q    <= nxt0_c;
      slot1_q    <= nxt1_c;
      halted     <= halted | ill_c;
      issued_cnt <= issued_cnt + CNT_W'(eff_c);
    end
  end

  // Vacated slots are cleared on the way in, so invalid slots already read as zero.
  assign uop0_valid = (occ_q != 2'd0);
  assign uop0_cls   = slot0_q.cls;
  assign uop0_rd    = slot0_q.rd;
  assign uop0_rs1   = slot0_q.rs1;
  assign uop0_rs2   = slot0_q.rs2;
  assign uop0_imm   = slot0_q.imm;
  assign uop0_sub   = slot0_q.sub;
  assign uop1_valid = (occ_q == 2'd2);
  assign uop1_cls   = slot1_q.cls;
  assign uop1_rd    = slot1_q.rd;
  assign uop1_rs1   = slot1_q.rs1;
  assign uop1_rs2   = slot1_q.rs2;
  assign uop1_imm   = slot1_q.imm;
  assign uop1_sub   = slot1_q.sub;

endmodule

// File: tb/tb_dual_issue_decoder.sv
// Directed scoreboard bench for dual_issue_decoder.
module tb_dual_issue_decoder;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr1, instr2;
  logic [1:0]  shift_count, accept_count;
  logic        uop0_valid, uop0_sub, uop1_valid, uop1_sub, halted;
  logic [2:0]  uop0_cls, uop1_cls;
  logic [4:0]  uop0_rd, uop0_rs1, uop0_rs2, uop1_rd, uop1_rs1, uop1_rs2;
  logic [31:0] uop0_imm, uop1_imm;
  logic [15:0] issued_cnt;

  dual_issue_decoder dut (
    .clk(clk), .reset(reset), .instr1(instr1), .instr2(instr2),
    .shift_count(shift_count), .accept_count(accept_count),
    .uop0_valid(uop0_valid), .uop0_cls(uop0_cls), .uop0_rd(uop0_rd),
    .uop0_rs1(uop0_rs1), .uop0_rs2(uop0_rs2), .uop0_imm(uop0_imm), .uop0_sub(uop0_sub),
    .uop1_valid(uop1_valid), .uop1_cls(uop1_cls), .uop1_rd(uop1_rd),
    .uop1_rs1(uop1_rs1), .uop1_rs2(uop1_rs2), .uop1_imm(uop1_imm), .uop1_sub(uop1_sub),
    .halted(halted), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  uop_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_issued = 0;
  logic exp_halted = 1'b0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDW = 32'h0072_80b3;
  localparam logic [31:0] MULW = 32'h0272_8133;
  localparam logic [31:0] BADW = 32'hffff_ffff;
  localparam logic [31:0] LDW1 = 32'h2440_2083;
  localparam logic [31:0] LDW2 = 32'h0f00_2103;

  function automatic uop_t mk(input uop_cls_e c, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic sub);
    uop_t u;
    u.cls = c; u.rd = rd; u.rs1 = rs1; u.rs2 = rs2; u.imm = imm; u.sub = sub;
    return u;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    uop_t e0, e1;
    e0 = (sb.size() > 0) ? sb[0] : uop_t'('0);
    e1 = (sb.size() > 1) ? sb[1] : uop_t'('0);
    check({tag, " valid0"}, 64'(uop0_valid), 64'(sb.size() > 0));
    check({tag, " valid1"}, 64'(uop1_valid), 64'(sb.size() > 1));
    check({tag, " slot0"},
          64'({uop0_cls, uop0_rd, uop0_rs1, uop0_rs2, uop0_imm, uop0_sub}), 64'(e0));
    check({tag, " slot1"},
          64'({uop1_cls, uop1_rd, uop1_rs1, uop1_rs2, uop1_imm, uop1_sub}), 64'(e1));
    check({tag, " halted"}, 64'(halted), 64'(exp_halted));
    check({tag, " issued"}, 64'(issued_cnt), 64'(16'(exp_issued)));
  endtask

  // One cycle: drive at negedge, compare, retire accepted entries, queue newly buffered ones.
  task automatic step(input string tag, input logic [31:0] i1, input logic [31:0] i2,
                      input logic [1:0] acc, input logic [1:0] exp_sh,
                      input int npush, input uop_t p0, input uop_t p1);
    int n_acc;
    instr1 = i1; instr2 = i2; accept_count = acc;
    #1;
    check({tag, " shift"}, 64'(shift_count), 64'(exp_sh));
    chk_outputs(tag);
    n_acc = (acc == 2'b11) ? 2 : int'(acc);
    if (n_acc > sb.size()) n_acc = sb.size();
    for (int i = 0; i < n_acc; i++) void'(sb.pop_front());
    exp_issued += n_acc;
    if (npush > 0) sb.push_back(p0);
    if (npush > 1) sb.push_back(p1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    exp_issued = 0;
    exp_halted = 1'b0;
    instr1 = NOP; instr2 = NOP; accept_count = 2'd0;
    #1;
    check({tag, " shift"}, 64'(shift_count), 64'(2'd2));
    chk_outputs(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  uop_t none, ld1, ld2, add, mul, add15, sub, st, addi;

  initial begin
    none  = '0;
    ld1   = mk(CLS_LOAD,  5'd1, 5'd0, 5'd0, 32'd580, 1'b0);
    ld2   = mk(CLS_LOAD,  5'd2, 5'd0, 5'd0, 32'd240, 1'b0);
    add   = mk(CLS_ALU,   5'd1, 5'd5, 5'd7, 32'd0, 1'b0);
    mul   = mk(CLS_MUL,   5'd2, 5'd5, 5'd7, 32'd0, 1'b0);
    add15 = mk(CLS_ALU,   5'd1, 5'd1, 5'd5, 32'd0, 1'b0);
    sub   = mk(CLS_ALU,   5'd2, 5'd1, 5'd2, 32'd0, 1'b1);
    st    = mk(CLS_STORE, 5'd0, 5'd2, 5'd5, 32'hffff_fffc, 1'b0);
    addi  = mk(CLS_ALU,   5'd3, 5'd1, 5'd0, 32'hffff_ffff, 1'b0);

    reset = 1'b1; instr1 = NOP; instr2 = NOP; accept_count = 2'd0;
    @(negedge clk); @(negedge clk);
    chk_outputs("reset");
    reset = 1'b0;

    step("loads_in",  LDW1, LDW2, 2'd0, 2'd2, 2, ld1, ld2);
    step("loads_buf", NOP,  NOP,  2'd0, 2'd0, 0, none, none);
    step("acc1_full", ADDW, MULW, 2'd1, 2'd0, 0, none, none);
    step("refill1",   ADDW, MULW, 2'd0, 2'd1, 1, add, none);
    step("drain2",    NOP,  NOP,  2'd2, 2'd0, 0, none, none);
    step("add_mul",   ADDW, MULW, 2'd0, 2'd2, 2, add, mul);
    step("add_mul_b", NOP,  NOP,  2'd2, 2'd0, 0, none, none);
    step("nop_skip",  NOP,  32'h0050_80b3, 2'd0, 2'd2, 1, add15, none);
    step("sub_in",    32'h4020_8133, NOP, 2'd0, 2'd1, 1, sub, none);
    step("acc3_full", NOP,  NOP,  2'b11, 2'd0, 0, none, none);
    step("st_addi",   32'hfe51_2e23, 32'hfff0_8193, 2'd0, 2'd2, 2, st, addi);
    step("st_addi_b", NOP,  NOP,  2'b11, 2'd0, 0, none, none);

    step("ill2_in",   ADDW, BADW, 2'd0, 2'd1, 1, add, none);
    exp_halted = 1'b1;
    step("halted_a",  ADDW, ADDW, 2'd0, 2'd0, 0, none, none);
    step("halt_drain", ADDW, ADDW, 2'd1, 2'd0, 0, none, none);
    step("halted_b",  NOP,  NOP,  2'd0, 2'd0, 0, none, none);
    mid_cycle_reset("rst_halted");

    step("fill_rst",  LDW1, LDW2, 2'd0, 2'd2, 2, ld1, ld2);
    mid_cycle_reset("rst_full");

    step("one_add",   ADDW, NOP,  2'd0, 2'd2, 1, add, none);
    step("acc3_occ1", NOP,  NOP,  2'b11, 2'd1, 0, none, none);
    step("ill1_in",   BADW, ADDW, 2'd0, 2'd0, 0, none, none);
    exp_halted = 1'b1;
    step("ill1_after", BADW, ADDW, 2'd0, 2'd0, 0, none, none);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
